// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong match sequencer that owns ball direction, serve timing, scoring and game-over.
module pong_game_ctrl #(
  parameter int SCORE_LIMIT  = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_FRAMES   = 180
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Frame_Start,
  input  logic       i_Start,
  input  logic       i_Hit_Top,
  input  logic       i_Hit_Bottom,
  input  logic       i_Hit_P1,
  input  logic       i_Hit_P2,
  input  logic       i_Miss_Left,
  input  logic       i_Miss_Right,
  output logic       o_HDir,
  output logic       o_VDir,
  output logic       o_Ball_En,
  output logic       o_Ball_Centre,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic [1:0] o_Winner,
  output logic       o_Game_Active
);
  localparam int MAXF = (SERVE_FRAMES > WIN_FRAMES) ? SERVE_FRAMES : WIN_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);
  localparam logic [3:0] LIM = 4'(SCORE_LIMIT);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAME_OVER} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0] win_q, win_d;
  logic hdir_q, hdir_d, vdir_q, vdir_d, en_q, en_d, centre_q, centre_d;
  logic active_q, active_d, start_q, miss_left_q, miss_left_d, start_edge;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    win_d       = win_q;
    hdir_d      = hdir_q;
    vdir_d      = vdir_q;
    miss_left_d = miss_left_q;
    start_edge  = i_Start & ~start_q;
    unique case (state_q)
      IDLE: if (start_edge) begin
        p1_d    = '0;
        p2_d    = '0;
        win_d   = '0;
        hdir_d  = 1'b0;
        vdir_d  = 1'b1;
        cnt_d   = '0;
        state_d = SERVE;
      end
      SERVE: if (i_Frame_Start) begin
        cnt_d   = (cnt_q == CW'(SERVE_FRAMES - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SERVE_FRAMES - 1)) ? PLAY : SERVE;
      end
      PLAY: if (i_Miss_Left | i_Miss_Right) begin
        // a miss freezes direction so the conceding side is remembered cleanly
        miss_left_d = i_Miss_Left;
        p2_d        = i_Miss_Left ? p2_q + {3'b0, p2_q < LIM} : p2_q;
        p1_d        = i_Miss_Left ? p1_q : p1_q + {3'b0, p1_q < LIM};
        state_d     = POINT;
      end else begin
        vdir_d = (i_Hit_Top ^ i_Hit_Bottom) ? i_Hit_Bottom : vdir_q;
        hdir_d = (i_Hit_P1 ^ i_Hit_P2) ? i_Hit_P2 : hdir_q;
      end
      POINT: begin
        cnt_d = '0;
        if (miss_left_q ? (p2_q == LIM) : (p1_q == LIM)) begin
          win_d   = miss_left_q ? 2'b10 : 2'b01;
          state_d = GAME_OVER;
        end else begin
          hdir_d  = miss_left_q;
          vdir_d  = ~vdir_q;
          state_d = SERVE;
        end
      end
      GAME_OVER: if (i_Frame_Start) begin
        cnt_d   = (cnt_q == CW'(WIN_FRAMES - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIN_FRAMES - 1)) ? IDLE : GAME_OVER;
      end
      default: state_d = IDLE;
    endcase
    en_d     = state_d == PLAY;
    centre_d = state_d inside {IDLE, SERVE, GAME_OVER};
    active_d = state_d inside {SERVE, PLAY, POINT};
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      win_q       <= '0;
      hdir_q      <= 1'b0;
      vdir_q      <= 1'b1;
      en_q        <= 1'b0;
      centre_q    <= 1'b1;
      active_q    <= 1'b0;
      start_q     <= 1'b0;
      miss_left_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      win_q       <= win_d;
      hdir_q      <= hdir_d;
      vdir_q      <= vdir_d;
      en_q        <= en_d;
      centre_q    <= centre_d;
      active_q    <= active_d;
      start_q     <= i_Start;
      miss_left_q <= miss_left_d;
    end
  end
  assign o_HDir        = hdir_q;
  assign o_VDir        = vdir_q;
  assign o_Ball_En     = en_q;
  assign o_Ball_Centre = centre_q;
  assign o_P1_Score    = p1_q;
  assign o_P2_Score    = p2_q;
  assign o_Winner      = win_q;
  assign o_Game_Active = active_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed bench for the Pong match sequencer with default parameters.
module tb_pong_game_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic frame = 0, start = 0, top = 0, bot = 0, hp1 = 0, hp2 = 0, ml = 0, mr = 0;
  logic hdir, vdir, en, centre, active;
  logic [3:0] p1, p2;
  logic [1:0] win;
  int checks = 0, errors = 0;
  pong_game_ctrl dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Start(frame), .i_Start(start),
    .i_Hit_Top(top), .i_Hit_Bottom(bot), .i_Hit_P1(hp1), .i_Hit_P2(hp2),
    .i_Miss_Left(ml), .i_Miss_Right(mr), .o_HDir(hdir), .o_VDir(vdir),
    .o_Ball_En(en), .o_Ball_Centre(centre), .o_P1_Score(p1), .o_P2_Score(p2),
    .o_Winner(win), .o_Game_Active(active)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame = 1; tick(); frame = 0; tick();
    end
  endtask
  task automatic rally(input logic l, input logic r);
    frames(60);
    ml = l; mr = r; tick(); ml = 0; mr = 0; tick();
  endtask
  initial begin
    tick(); tick();
    chk("rst_hdir", hdir, 0); chk("rst_vdir", vdir, 1); chk("rst_en", en, 0);
    chk("rst_centre", centre, 1); chk("rst_p1", p1, 0); chk("rst_p2", p2, 0);
    chk("rst_win", win, 0); chk("rst_active", active, 0);
    rst_n = 1; tick();
    start = 1; tick();
    chk("serve_active", active, 1); chk("serve_en", en, 0); chk("serve_centre", centre, 1);
    frames(59);
    chk("serve59_en", en, 0);
    frame = 1; tick(); frame = 0; start = 0;
    chk("play_en", en, 1); chk("play_centre", centre, 0);
    chk("play_hdir", hdir, 0); chk("play_vdir", vdir, 1);
    hp2 = 1; tick(); hp2 = 0;
    chk("p2hit_h", hdir, 1); chk("p2hit_v", vdir, 1);
    top = 1; tick(); top = 0;
    chk("top_h", hdir, 1); chk("top_v", vdir, 0);
    top = 1; hp1 = 1; tick(); top = 0; hp1 = 0;
    chk("both_h", hdir, 0); chk("both_v", vdir, 0);
    top = 1; bot = 1; hp1 = 1; hp2 = 1; tick(); top = 0; bot = 0; hp1 = 0; hp2 = 0;
    chk("tb_h_hold", hdir, 0); chk("tb_v_hold", vdir, 0);
    hp2 = 1; bot = 1; tick(); hp2 = 0; bot = 0;
    chk("indep_h", hdir, 1); chk("indep_v", vdir, 1);
    ml = 1; hp1 = 1; tick(); ml = 0; hp1 = 0;
    chk("miss_p2", p2, 1); chk("miss_hdir", hdir, 1); chk("point_en", en, 0);
    chk("point_active", active, 1);
    tick();
    chk("reserve_h", hdir, 1); chk("reserve_v", vdir, 0); chk("reserve_centre", centre, 1);
    rally(1, 1);
    chk("dual_p1", p1, 0); chk("dual_p2", p2, 2);
    for (int i = 0; i < 8; i++) rally(0, 1);
    chk("p1_8", p1, 8); chk("p1_8_active", active, 1);
    frames(60);
    mr = 1; tick(); mr = 0;
    chk("p1_9", p1, 9); chk("point9_win", win, 0);
    tick();
    chk("go_win", win, 1); chk("go_active", active, 0); chk("go_centre", centre, 1);
    chk("go_p2", p2, 2);
    frames(179);
    start = 1; tick();
    chk("go_start_ign", active, 0);
    frame = 1; tick(); frame = 0; tick(); tick();
    chk("idle_held", active, 0); chk("idle_p1", p1, 9); chk("idle_win", win, 1);
    start = 0; tick();
    chk("idle_rel", active, 0);
    start = 1; frame = 1; tick(); frame = 0; start = 0;
    chk("restart_active", active, 1); chk("restart_p1", p1, 0);
    chk("restart_p2", p2, 0); chk("restart_win", win, 0);
    frames(59);
    chk("entry_frame_en", en, 0);
    frame = 1; tick(); frame = 0;
    chk("entry_play_en", en, 1);
    ml = 1; tick(); ml = 0; tick();
    for (int i = 0; i < 4; i++) rally(1, 0);
    for (int i = 0; i < 3; i++) rally(0, 1);
    frames(60);
    hp2 = 1; top = 1; tick(); hp2 = 0; top = 0;
    chk("mid_p1", p1, 3); chk("mid_p2", p2, 5); chk("mid_h", hdir, 1); chk("mid_en", en, 1);
    #2 rst_n = 0; #1;
    chk("arst_hdir", hdir, 0); chk("arst_vdir", vdir, 1); chk("arst_en", en, 0);
    chk("arst_centre", centre, 1); chk("arst_p1", p1, 0); chk("arst_p2", p2, 0);
    chk("arst_win", win, 0); chk("arst_active", active, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Match sequencer for the Pong ball datapath. Owns ball direction, ball enable/centre-hold, serve timing, scoring and game-over.
- Sits between the collision/edge detectors (paddle, wall, miss events) and the ball position counters.
- Replaces the switch-driven development direction control in production builds.

Parameters:
SCORE_LIMIT, 9, points needed to win; legal range 1..15.
SERVE_FRAMES, 60, frame pulses the ball is held at centre before each serve; must be >= 1.
WIN_FRAMES, 180, frame pulses the GAME_OVER state is held before returning to IDLE; must be >= 1.

Ports:
i_Clk  in  1  system clock; all logic on its rising edge.
i_Rst_L  in  1  asynchronous active-low reset.
i_Frame_Start  in  1  one-cycle pulse, once per video frame.
i_Start  in  1  start button, already debounced and level; edge-detected internally.
i_Hit_Top  in  1  ball touching top wall.
i_Hit_Bottom  in  1  ball touching bottom wall.
i_Hit_P1  in  1  ball touching left (P1) paddle.
i_Hit_P2  in  1  ball touching right (P2) paddle.
i_Miss_Left  in  1  ball passed left edge; P2 scores.
i_Miss_Right  in  1  ball passed right edge; P1 scores.
o_HDir  out  1  0 = right, 1 = left.
o_VDir  out  1  0 = down, 1 = up.
o_Ball_En  out  1  ball counters may advance.
o_Ball_Centre  out  1  ball counters forced to screen centre.
o_P1_Score  out  4  P1 score.
o_P2_Score  out  4  P2 score.
o_Winner  out  2  00 none, 01 P1, 10 P2.
o_Game_Active  out  1  high in SERVE, PLAY and POINT.

Behaviour:
- Reset values:
  - State IDLE.
  - HDir 0, VDir 1.
  - Ball_En 0, Ball_Centre 1.
  - Both scores 0, Winner 00, Game_Active 0.
  - Frame counter 0.
  - Start edge register 0.
- All outputs are registered. An input event in cycle N is visible on the outputs in cycle N+1.
- Start edge: i_Start high now and low in the previous cycle.

State machine:
- IDLE:
  - Ball_Centre=1, Ball_En=0. Scores and Winner keep their last values.
  - On a start edge: clear scores and Winner, HDir=0, VDir=1, frame counter=0, go to SERVE.
- SERVE:
  - Ball_Centre=1, Ball_En=0.
  - Count i_Frame_Start pulses. Exactly on the SERVE_FRAMES-th pulse, go to PLAY.
  - Hit and miss inputs are ignored.
- PLAY:
  - Ball_Centre=0, Ball_En=1.
  - i_Hit_Top -> VDir=0. i_Hit_Bottom -> VDir=1.
  - i_Hit_P1 -> HDir=0. i_Hit_P2 -> HDir=1.
  - H and V updates are independent and may occur in the same cycle.
  - i_Miss_Left -> P2 score +1, go to POINT. i_Miss_Right -> P1 score +1, go to POINT.
- POINT (one cycle):
  - Ball_En=0.
  - If the incremented score equals SCORE_LIMIT: Winner set, frame counter=0, go to GAME_OVER.
  - Otherwise: serve toward the player who conceded (left miss -> HDir=1, right miss -> HDir=0), VDir toggles, frame counter=0, go to SERVE.
- GAME_OVER:
  - Ball_Centre=1, Ball_En=0.
  - Count WIN_FRAMES frame pulses, then go to IDLE. Winner and scores are held.
  - Start edges are ignored.

Priorities and boundaries:
- In PLAY, a miss beats any hit in the same cycle; direction is not updated in that cycle.
- i_Miss_Left beats i_Miss_Right if both are asserted; only P2 scores.
- i_Hit_P1 and i_Hit_P2 together: HDir unchanged. i_Hit_Top and i_Hit_Bottom together: VDir unchanged.
- i_Start held across return to IDLE does not restart the game; a fresh rising edge is required.
- Scores never exceed SCORE_LIMIT; no wrap.
- i_Frame_Start in the same cycle as a state entry is not counted.
- Asynchronous reset mid-game returns immediately to the reset values listed above.

Test Plan:
1. Reset, start edge, 60 frame pulses -> SERVE entered 1 cycle after the edge; PLAY entered 1 cycle after the 60th pulse; Ball_En=1, HDir=0, VDir=1.
2. In PLAY, pulse i_Hit_P2, then i_Hit_Top, then i_Hit_Top and i_Hit_P1 in the same cycle -> HDir/VDir go 1/1, then 1/0, then 0/0.
3. In PLAY, i_Miss_Left with i_Hit_P1 in the same cycle -> P2 score 1, HDir stays 1 through POINT, next serve HDir=1, VDir=0.
4. P1 wins 9 rallies -> o_P1_Score=9, o_Winner=01, GAME_OVER held for 180 frames, then IDLE with score 9 still shown; start edge clears both scores to 0.
5. Assert i_Rst_L low mid-PLAY with score 3:5 -> outputs return to reset values asynchronously, before the next clock edge.
6. i_Start held high from GAME_OVER into IDLE -> stays in IDLE; release then press -> SERVE.
